// File: rtl/papuf_eval_ctrl.sv
// papuf_eval_ctrl: sequences PUF challenge/pulse/settle/sample evaluations and returns the response.
// Optional majority voting over NUM_VOTES evaluations when PAPUF_MAJORITY_VOTE_EN is defined.
module papuf_eval_ctrl #(
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 8,
    parameter int NUM_VOTES     = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_challenge,
    output logic [15:0] puf_challenge,
    output logic        puf_pulse,
    input  logic [15:0] puf_response,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_stable,
    output logic        busy
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] PULSE  = 3'd2;
    localparam logic [2:0] SETTLE = 3'd3;
    localparam logic [2:0] SAMPLE = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [7:0] PEND   = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] SEND   = 8'(SETTLE_CYCLES - 1);

    logic [2:0]  state, nxt;
    logic [7:0]  cnt;
    logic [15:0] s1, s2;
    logic        last, accept;

    assign accept    = state == IDLE && req_valid;
    assign req_ready = state == IDLE;
    assign rsp_valid = state == DONE;
    assign busy      = state != IDLE;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = req_valid ? SETUP : IDLE;
            SETUP:   nxt = PULSE;
            PULSE:   nxt = cnt == PEND ? SETTLE : PULSE;
            SETTLE:  nxt = cnt == SEND ? SAMPLE : SETTLE;
            SAMPLE:  nxt = last ? DONE : PULSE;
            DONE:    nxt = rsp_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end

    // puf_pulse is registered from the next state so it is high exactly while in PULSE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            puf_pulse     <= 1'b0;
            puf_challenge <= '0;
            s1            <= '0;
            s2            <= '0;
        end else begin
            state     <= nxt;
            cnt       <= (nxt == state && (state == PULSE || state == SETTLE)) ? cnt + 8'd1 : 8'd0;
            puf_pulse <= nxt == PULSE;
            s1        <= puf_response;
            s2        <= s1;
            if (accept)
                puf_challenge <= req_challenge;
        end
    end

`ifdef PAPUF_MAJORITY_VOTE_EN
    logic [2:0] ev;
    logic [2:0] ones [16];

    assign last = ev == 3'(NUM_VOTES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev <= '0;
            for (int i = 0; i < 16; i++)
                ones[i] <= '0;
        end else if (accept) begin
            ev <= '0;
            for (int i = 0; i < 16; i++)
                ones[i] <= '0;
        end else if (state == SAMPLE) begin
            ev <= ev + 3'd1;
            for (int i = 0; i < 16; i++)
                ones[i] <= ones[i] + {2'b0, s2[i]};
        end
    end

    always_comb begin
        rsp_data   = '0;
        rsp_stable = state == DONE;
        for (int i = 0; i < 16; i++) begin
            rsp_data[i] = ones[i] >= 3'((NUM_VOTES + 1) / 2);
            if (ones[i] != 3'd0 && ones[i] != 3'(NUM_VOTES))
                rsp_stable = 1'b0;
        end
    end
`else
    logic [15:0] smp;

    assign last       = 1'b1;
    assign rsp_data   = smp;
    assign rsp_stable = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            smp <= '0;
        else if (state == SAMPLE)
            smp <= s2;
    end
`endif
endmodule

// File: tb/tb_papuf_eval_ctrl.sv
// tb_papuf_eval_ctrl: randomized and directed checks of papuf_eval_ctrl against a cycle-count/majority model.
module tb_papuf_eval_ctrl;
    localparam int P   = 2;
    localparam int S   = 8;
    localparam int TOT = P + S + 1;
`ifdef PAPUF_MAJORITY_VOTE_EN
    localparam int N = 5;
`else
    localparam int N = 1;
`endif

    logic        clk = 0;
    logic        rst_n = 0;
    logic        req_valid = 0;
    logic        req_ready;
    logic [15:0] req_challenge = 0;
    logic [15:0] puf_challenge;
    logic        puf_pulse;
    logic [15:0] puf_response = 0;
    logic        rsp_valid;
    logic        rsp_ready = 0;
    logic [15:0] rsp_data;
    logic        rsp_stable;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] vals [7];

    papuf_eval_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_challenge(req_challenge), .puf_challenge(puf_challenge), .puf_pulse(puf_pulse),
        .puf_response(puf_response), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_stable(rsp_stable), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, o, e);
        end
    endtask

    // One request; vals[] supplies the PUF output for each evaluation.
    task automatic txn(input logic [15:0] ch, input int hold, input bit keep);
        logic [15:0] ed;
        logic        es;
        int          cyc;
        int          c;
        es = 1;
        ed = '0;
        for (int b = 0; b < 16; b++) begin
            c = 0;
            for (int e = 0; e < N; e++)
                c += int'(vals[e][b]);
            ed[b] = 2 * c > N;
            if (c != 0 && c != N) es = 0;
        end
        chk("accept_ready", {31'b0, req_ready}, 1);
        req_challenge = ch;
        req_valid = 1;
        @(negedge clk);
        cyc = 1;
        if (!keep) req_valid = 0;
        while (!rsp_valid && cyc < 200) begin
            if (cyc >= 2 && cyc < 2 + N * TOT && (cyc - 2) % TOT == 0)
                puf_response = vals[(cyc - 2) / TOT];
            if (cyc == 5) req_challenge = ~ch;
            chk("pulse", {31'b0, puf_pulse},
                {31'b0, cyc >= 2 && cyc < 2 + N * TOT && (cyc - 2) % TOT < P});
            chk("chal_run", {16'b0, puf_challenge}, {16'b0, ch});
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, 2 + N * TOT);
        chk("data", {16'b0, rsp_data}, {16'b0, ed});
        chk("stable", {31'b0, rsp_stable}, {31'b0, es});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, rsp_valid}, 1);
            chk("hold_data", {16'b0, rsp_data}, {16'b0, ed});
            chk("hold_chal", {16'b0, puf_challenge}, {16'b0, ch});
            chk("hold_ready", {31'b0, req_ready}, 0);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("post_valid", {31'b0, rsp_valid}, 0);
        chk("post_busy", {31'b0, busy}, 0);
    endtask

    initial begin
        #12;
        chk("rst_pulse", {31'b0, puf_pulse}, 0);
        chk("rst_chal", {16'b0, puf_challenge}, 0);
        chk("rst_valid", {31'b0, rsp_valid}, 0);
        chk("rst_data", {16'b0, rsp_data}, 0);
        chk("rst_stable", {31'b0, rsp_stable}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 1);

        for (int e = 0; e < 7; e++) vals[e] = 16'h1234;
`ifdef PAPUF_MAJORITY_VOTE_EN
        vals[0] = 16'h00F1; vals[1] = 16'h00F0; vals[2] = 16'h00F1;
        vals[3] = 16'h00F1; vals[4] = 16'h00F0;
`endif
        txn(16'hA5C3, 0, 0);
        txn(16'h5A3C, 20, 0);

        for (int t = 0; t < 6; t++) begin
            for (int e = 0; e < 7; e++)
                vals[e] = ($urandom_range(0, 1) != 0) ? 16'($urandom) : vals[0];
            txn(16'($urandom), int'($urandom_range(0, 4)), 1);
        end
        req_valid = 0;
        @(negedge clk);

        req_challenge = 16'hBEEF;
        req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        chk("mid_pulse_hi", {31'b0, puf_pulse}, 1);
        #2 rst_n = 0;
        #1;
        chk("async_pulse", {31'b0, puf_pulse}, 0);
        chk("async_busy", {31'b0, busy}, 0);
        chk("async_chal", {16'b0, puf_challenge}, 0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_rsp", {31'b0, rsp_valid}, 0);
        end
        chk("rel_ready", {31'b0, req_ready}, 1);
        chk("rel_busy", {31'b0, busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/papuf_eval_ctrl.md
PAPUF_EVAL_CTRL -- requirements
Module: papuf_eval_ctrl

Interface
REQ-001 Parameter PULSE_CYCLES, default 2, is the number of cycles puf_pulse is held high per evaluation (legal range 1..15).
REQ-002 Parameter SETTLE_CYCLES, default 8, is the number of cycles waited after pulse fall before sampling (legal range 2..255).
REQ-003 Parameter NUM_VOTES, default 5, is the number of evaluations per request when voting is compiled in (odd, 3..7).
REQ-004 clk  input  1  single clock for the whole block.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  1  challenge request valid.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_challenge  input  16  challenge to evaluate.
REQ-009 puf_challenge  output  16  challenge driven to the 16-bit PUF array.
REQ-010 puf_pulse  output  1  excitation pulse driven to the PUF array.
REQ-011 puf_response  input  16  raw, asynchronous PUF array response.
REQ-012 rsp_valid  output  1  response word valid.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_data  output  16  final (voted) response.
REQ-015 rsp_stable  output  1  all evaluations agreed on every bit.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP, PULSE, SETTLE, SAMPLE and DONE.
REQ-018 req_ready SHALL be high only in IDLE; a request SHALL be accepted on req_valid & req_ready, latching req_challenge into puf_challenge and moving to SETUP.
REQ-019 SETUP SHALL last 1 cycle with puf_pulse low, then go to PULSE.
REQ-020 PULSE SHALL hold puf_pulse high for exactly PULSE_CYCLES cycles, then go to SETTLE; puf_pulse SHALL be a register output, glitch-free.
REQ-021 SETTLE SHALL last SETTLE_CYCLES cycles with puf_pulse low, then go to SAMPLE.
REQ-022 puf_response SHALL pass through a 2-flop synchronizer at all times; SAMPLE SHALL capture the synchronizer output in 1 cycle.
REQ-023 After SAMPLE the FSM SHALL return to PULSE while evaluations remain, else go to DONE.
REQ-024 Latency from accept edge to rsp_valid high SHALL be 2 + N*(PULSE_CYCLES+SETTLE_CYCLES+1) cycles, where N is the number of evaluations (13 cycles for defaults, N=1).
REQ-025 puf_challenge SHALL stay constant from accept until the DONE-to-IDLE transition.
REQ-026 In DONE, rsp_valid SHALL be high and rsp_data and rsp_stable SHALL stay constant until rsp_ready; on rsp_valid & rsp_ready the FSM SHALL go to IDLE.
REQ-027 A new request SHALL NOT be accepted in the same cycle as the response handshake; the earliest accept is the following cycle.
REQ-028 req_valid asserted outside IDLE SHALL be ignored and SHALL NOT alter any state.

Reset
REQ-029 On rst_n low, the block SHALL immediately go to IDLE and clear all outputs and internal state: puf_pulse=0, puf_challenge=0, rsp_valid=0, rsp_data=0, rsp_stable=0, busy=0, synchronizer=0, vote counters=0.
REQ-030 req_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-031 Reset asserted mid-evaluation, including during PULSE, SHALL drop puf_pulse asynchronously and discard the partial result; no rsp_valid SHALL follow.

Configuration
REQ-032 With PAPUF_MAJORITY_VOTE_EN defined, N SHALL be NUM_VOTES, and each bit SHALL have a 3-bit one-counter; rsp_data[i] SHALL be 1 when its count >= (NUM_VOTES+1)/2, and rsp_stable SHALL be 1 when every count is 0 or NUM_VOTES.
REQ-033 Without PAPUF_MAJORITY_VOTE_EN, N SHALL be 1, no counters SHALL exist, rsp_data SHALL equal the single sample, and rsp_stable SHALL be 1 in DONE.

Verification
REQ-034 Default parameters, no macro, challenge 16'hA5C3, PUF model returns 16'h1234 -> pulse high cycles 2-3, rsp_valid at cycle 13, rsp_data=16'h1234, rsp_stable=1.
REQ-035 Macro on, model bit 0 returns 1,0,1,1,0 and the other bits constant 16'h00F0 -> rsp_data=16'h00F1, rsp_stable=0, rsp_valid at cycle 57.
REQ-036 rsp_ready held low 20 cycles in DONE -> rsp_data and rsp_valid stable, puf_challenge unchanged, req_ready=0.
REQ-037 req_valid held high throughout -> second request accepted exactly 1 cycle after the response handshake; a req_challenge change mid-evaluation does not affect puf_challenge.
REQ-038 rst_n pulsed low during PULSE -> puf_pulse=0 with no clock edge, busy=0, no rsp_valid, req_ready=1 after release.
